// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the nibble-serial carry-lookahead adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Request/response bundle for cla_nibble_sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, in_a, in_b, in_cin, out_valid, out_ready, out_sum, out_cout, busy.
interface cla_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  import cla_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  // Requester / consumer side.
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

endinterface

// File: rtl/cla_nibble_sequencer_adder.sv
// Carry_lookahead_adder: combinational 4-bit carry-lookahead adder.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a_i, b_i (4-bit addends), cin_i (carry-in), s_o (4-bit sum), cout_o (carry-out).
module Carry_lookahead_adder
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded directly from g/p and cin, no ripple chain.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial adder: {out_cout,out_sum} = in_a + in_b + in_cin through one shared 4-bit CLA, LS nibble first.
// Latency: out_valid rises NIBBLES cycles after the accepting edge; one op per NIBBLES+2 cycles at full rate.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then back to IDLE.
// Ports: clk, rst (sync, active-high), bus (slave modport of cla_nibble_sequencer_if).
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_nibble_sequencer_if.slave bus
);

  localparam int                W        = NIBBLE_W * NIBBLES;
  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          sum_q, sum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;

  logic [NIBBLE_W-1:0]   nib_a, nib_b, nib_s;
  logic                  nib_cout;

  // The carry register is loaded with in_cin at acceptance, so it already
  // holds the right carry-in for nibble 0.
  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  Carry_lookahead_adder u_cla (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for cla_nibble_sequencer at NIBBLES=4 and NIBBLES=1.
// Expected sums come from plain integer addition; a monitor per DUT pops and compares.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_nibble_sequencer_if #(.NIBBLES(4)) b4 ();
  cla_nibble_sequencer_if #(.NIBBLES(1)) b1 ();

  cla_nibble_sequencer #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  cla_nibble_sequencer #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_bp = 1'b0;

  logic [16:0] exp4_q[$];
  int          lat4_q[$];
  logic [4:0]  exp1_q[$];
  int          lat1_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon4
    bit pv, phs;
    pv = 1'b0; phs = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pv = 1'b0; phs = 1'b0;
      end else begin
        if (phs) check("valid_one_cycle4", 32'(b4.out_valid), 32'd0);
        if (b4.out_valid && !pv) begin
          if (lat4_q.size() == 0) check("spurious_valid4", 32'(b4.out_valid), 32'd0);
          else check("latency4", cyc, lat4_q.pop_front());
        end
        phs = b4.out_valid && b4.out_ready;
        if (phs) begin
          if (exp4_q.size() == 0) check("spurious_result4", 32'(b4.out_valid), 32'd0);
          else check("result4", 32'({b4.out_cout, b4.out_sum}), 32'(exp4_q.pop_front()));
        end
        pv = b4.out_valid;
      end
    end
  end

  initial begin : mon1
    bit pv, phs;
    pv = 1'b0; phs = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pv = 1'b0; phs = 1'b0;
      end else begin
        if (phs) check("valid_one_cycle1", 32'(b1.out_valid), 32'd0);
        if (b1.out_valid && !pv) begin
          if (lat1_q.size() == 0) check("spurious_valid1", 32'(b1.out_valid), 32'd0);
          else check("latency1", cyc, lat1_q.pop_front());
        end
        phs = b1.out_valid && b1.out_ready;
        if (phs) begin
          if (exp1_q.size() == 0) check("spurious_result1", 32'(b1.out_valid), 32'd0);
          else check("result1", 32'({b1.out_cout, b1.out_sum}), 32'(exp1_q.pop_front()));
        end
        pv = b1.out_valid;
      end
    end
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c, output int acc);
    bit rdy;
    int n;
    n = 0;
    b4.in_valid = 1'b1; b4.in_a = a; b4.in_b = b; b4.in_cin = c;
    forever begin
      rdy = b4.in_ready;
      if (rnd_bp) b4.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        check("accept_timeout4", 32'(b4.in_ready), 32'd1);
        break;
      end
    end
    acc = cyc;
    exp4_q.push_back(17'(a) + 17'(b) + 17'(c));
    lat4_q.push_back(acc + 4);
    b4.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic c, output int acc);
    bit rdy;
    int n;
    n = 0;
    b1.in_valid = 1'b1; b1.in_a = a; b1.in_b = b; b1.in_cin = c;
    forever begin
      rdy = b1.in_ready;
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        check("accept_timeout1", 32'(b1.in_ready), 32'd1);
        break;
      end
    end
    acc = cyc;
    exp1_q.push_back(5'(a) + 5'(b) + 5'(c));
    lat1_q.push_back(acc + 1);
    b1.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    rnd_bp = 1'b0;
    b4.out_ready = 1'b1;
    while ((exp4_q.size() != 0 || b4.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout4", exp4_q.size() + 32'(b4.busy), 32'd0);
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while ((exp1_q.size() != 0 || b1.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout1", exp1_q.size() + 32'(b1.busy), 32'd0);
  endtask

  task automatic check_idle4(input string tag);
    check({tag, "_out_valid"}, 32'(b4.out_valid), 32'd0);
    check({tag, "_out_sum"},   32'(b4.out_sum),   32'd0);
    check({tag, "_out_cout"},  32'(b4.out_cout),  32'd0);
    check({tag, "_busy"},      32'(b4.busy),      32'd0);
    check({tag, "_in_ready"},  32'(b4.in_ready),  32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int acc1, acc2, acc3, rel, n;
    logic [15:0] ra, rb, xa, xb;
    logic        rc, xc;
    logic [16:0] hold_exp;

    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_cin = 1'b0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_cin = 1'b0; b1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle4("reset4");
    check("reset1_out_valid", 32'(b1.out_valid), 32'd0);
    check("reset1_in_ready",  32'(b1.in_ready),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripples through every nibble.
    send4(16'h0001, 16'hFFFF, 1'b0, acc1);
    drain4();

    // Back-to-back with in_valid held: spacing is NIBBLES+2.
    send4(16'h1234, 16'h4321, 1'b1, acc1);
    send4(16'hBBBB, 16'h6666, 1'b0, acc2);
    check("b2b_spacing4", acc2 - acc1, 32'd6);
    drain4();

    // Backpressure in DONE with a competing request.
    b4.out_ready = 1'b0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
    hold_exp = 17'(ra) + 17'(rb) + 17'(rc);
    send4(ra, rb, rc, acc1);
    n = 0;
    while (!b4.out_valid && n < 20) begin @(negedge clk); n++; end
    xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
    b4.in_valid = 1'b1; b4.in_a = xa; b4.in_b = xb; b4.in_cin = xc;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(b4.out_valid), 32'd1);
      check("bp_hold_result", 32'({b4.out_cout, b4.out_sum}), 32'(hold_exp));
      check("bp_in_ready", 32'(b4.in_ready), 32'd0);
      @(negedge clk);
    end
    b4.out_ready = 1'b1;
    rel = cyc;
    send4(xa, xb, xc, acc3);
    check("bp_accept_cycle", acc3, rel + 2);
    drain4();

    // Reset abort after two RUN cycles.
    send4(16'($urandom), 16'($urandom), 1'($urandom), acc1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp4_q.delete(); lat4_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle4("abort4");
    send4(16'h00FF, 16'h0001, 1'b0, acc1);
    drain4();

    // Operand changes while running are ignored.
    send4(16'hA5A5, 16'h5A5B, 1'b1, acc1);
    for (int i = 0; i < 3; i++) begin
      b4.in_a = 16'($urandom); b4.in_b = 16'($urandom); b4.in_cin = 1'($urandom);
      @(negedge clk);
    end
    drain4();

    // Random traffic with random result backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send4(16'($urandom), 16'($urandom), 1'($urandom), acc1);
      n = $urandom_range(0, 2);
      repeat (n) begin
        b4.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end
    drain4();

    // Single-nibble instance.
    send1(4'hB, 4'h6, 1'b0, acc1);
    drain1();
    send1(4'hF, 4'hF, 1'b1, acc1);
    send1(4'h7, 4'h8, 1'b0, acc2);
    check("b2b_spacing1", acc2 - acc1, 32'd3);
    for (int i = 0; i < 8; i++) send1(4'($urandom), 4'($urandom), 1'($urandom), acc1);
    drain1();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_nibble_sequencer.md
CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: requester presents an operation.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-006 The block SHALL have ports in_a and in_b, input, W bits each: addend operands.
REQ-007 The block SHALL have port in_cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port out_sum, output, W bits: sum.
REQ-011 The block SHALL have port out_cout, output, 1 bit: final carry-out.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-013 The block SHALL compute {out_cout, out_sum} = in_a + in_b + in_cin, with all arithmetic modulo 2^(W+1), using one shared 4-bit carry-lookahead adder evaluated one nibble per cycle, least-significant nibble first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid=1 the block SHALL register in_a, in_b and in_cin, clear the nibble index and the sum register, and enter RUN.
REQ-016 In RUN, nibble idx of the registered operands, together with the carry register (in_cin for idx 0), SHALL drive the adder; on each edge the adder S output SHALL be stored into out_sum[4*idx+3:4*idx], Cout SHALL be stored into the carry register, and idx SHALL increment.
REQ-017 When idx = NIBBLES-1, the block SHALL, on that edge, store Cout into out_cout and enter DONE.
REQ-018 Latency: out_valid SHALL rise exactly NIBBLES cycles after the acceptance edge.
REQ-019 In DONE, out_valid SHALL be 1; out_sum and out_cout SHALL hold stable while out_ready=0; on out_ready=1 the block SHALL return to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid and in_a/in_b changes SHALL be ignored outside IDLE, and registered operands SHALL be unaffected.
REQ-021 Throughput SHALL be one operation per NIBBLES+2 cycles when out_ready is held at 1 and in_valid is held at 1.
REQ-022 out_sum and out_cout SHALL hold the last result in IDLE until the next acceptance clears them.
REQ-023 For NIBBLES=1, RUN SHALL last exactly one cycle.

Reset
REQ-024 While rst=1, the state SHALL be IDLE, and out_valid, out_sum, out_cout, busy, idx, the carry register and the operand registers SHALL be 0 on the edge; in_ready SHALL be 1 after the edge.
REQ-025 An assertion of rst in RUN or DONE SHALL abort the operation without emitting out_valid, and the next accepted operation SHALL compute correctly.

Structure
REQ-026 Constants NIBBLE_W=4 and the FSM state encodings SHALL reside in the shared package cla_pkg.
REQ-027 The existing Carry_lookahead_adder module SHALL be instantiated exactly once as the sole arithmetic sub-module; no other adder logic SHALL exist.

Verification
REQ-028 Directed test, NIBBLES=4, out_ready=1: a=0x0001, b=0xFFFF, cin=0 -> out_sum=0x0000 and out_cout=1, with out_valid asserted 4 cycles after acceptance for exactly 1 cycle.
REQ-029 Directed test: a=0x1234, b=0x4321, cin=1 -> out_sum=0x5556, out_cout=0; then a=0xBBBB, b=0x6666, cin=0 back-to-back -> out_sum=0x2221, out_cout=1, accepted 6 cycles after the first acceptance.
REQ-030 Directed test, backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, out_sum and out_cout held; in_ready=0; a new in_valid is ignored until after out_ready=1.
REQ-031 Directed test, reset: rst asserted for 1 cycle after 2 RUN cycles -> IDLE, out_valid=0, all outputs 0; a following a=0x00FF, b=0x0001, cin=0 -> out_sum=0x0100, out_cout=0.
REQ-032 Directed test, input change: in_a and in_b changed during RUN -> result still reflects the operands registered at acceptance.
REQ-033 Directed test, NIBBLES=1: a=0xB, b=0x6, cin=0 -> out_sum=0x1, out_cout=1, with out_valid asserted 1 cycle after acceptance.
